// File: rtl/alu_rx_sequencer_pkg.sv
// Shared definitions for the ALU byte-stream sequencer.
//   seq_state_t    : sequencer FSM states
//   OP_*           : ALU opcode constants (low NB_OP bits of the opcode byte)
//   FLG_*_BIT      : bit positions inside the returned flag byte
//   is_busy_state  : states in which an incoming byte cannot be accepted
package alu_rx_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_WAIT_A,
    ST_WAIT_B,
    ST_WAIT_OP,
    ST_EXEC,
    ST_CAPTURE,
    ST_TX_RES,
    ST_WAIT_RES,
    ST_TX_FLG,
    ST_WAIT_FLG
  } seq_state_t;

  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_AND = 6'h24;
  localparam logic [5:0] OP_OR  = 6'h25;
  localparam logic [5:0] OP_XOR = 6'h26;
  localparam logic [5:0] OP_NOR = 6'h27;
  localparam logic [5:0] OP_SRA = 6'h03;
  localparam logic [5:0] OP_SRL = 6'h02;

  localparam int FLG_ZERO_BIT = 0;
  localparam int FLG_OVF_BIT  = 1;

  function automatic logic is_busy_state(input seq_state_t s);
    return s inside {ST_EXEC, ST_CAPTURE, ST_TX_RES, ST_WAIT_RES, ST_TX_FLG, ST_WAIT_FLG};
  endfunction

endpackage

// File: rtl/alu_rx_sequencer_seq_timeout.sv
// Inter-byte timeout counter for the sequencer.
//   i_clk, i_rst : clock, asynchronous active-low reset
//   i_clr        : synchronous clear to zero (has priority over i_en)
//   i_en         : count one cycle
//   o_expire     : combinational, high while enabled and the count sits at TIMEOUT_CYC-1
module alu_rx_sequencer_seq_timeout #(
  parameter int NB_TIMEOUT  = 24,
  parameter int TIMEOUT_CYC = 10_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam logic [NB_TIMEOUT-1:0] LAST = NB_TIMEOUT'(TIMEOUT_CYC - 1);

  logic [NB_TIMEOUT-1:0] count;

  // Stops at LAST so a stalled enable can never wrap back through zero.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      count <= '0;
    end else if (i_clr) begin
      count <= '0;
    end else if (i_en && !o_expire) begin
      count <= count + 1'b1;
    end
  end

  assign o_expire = i_en && (count == LAST);

endmodule

// File: rtl/alu_rx_sequencer.sv
// Byte-stream front end for the registered ALU datapath.
// Collects A, B and OP bytes from the UART receiver, drives them onto the shared
// bus with one-cycle load strobes, captures the ALU result and flags, then sends
// the result byte followed by the flag byte to the UART transmitter.
//   i_clk, i_rst           : clock, asynchronous active-low reset
//   i_rx_data, i_rx_valid  : received byte and its one-cycle valid pulse
//   o_data                 : registered bus to the ALU top
//   o_en_A/o_en_B/o_en_OP  : one-cycle load strobes for the ALU registers
//   i_result, i_zero, i_overflow : ALU outputs
//   o_tx_data, o_tx_start  : byte to transmit and its one-cycle start pulse
//   i_tx_done              : transmitter finished the current byte
//   o_rx_overrun           : a byte arrived while busy and was discarded
module alu_rx_sequencer #(
  parameter int NB_DATA     = 8,
  parameter int NB_OP       = 6,
  parameter int NB_TIMEOUT  = 24,
  parameter int TIMEOUT_CYC = 10_000_000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_en_A,
  output logic               o_en_B,
  output logic               o_en_OP,
  input  logic [NB_DATA-1:0] i_result,
  input  logic               i_zero,
  input  logic               i_overflow,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic               o_rx_overrun
);

  import alu_rx_sequencer_pkg::*;

  // The ALU slices the opcode out of the same bus byte.
  if (NB_OP > NB_DATA) begin : g_op_width_check
    $error("NB_OP must not exceed NB_DATA");
  end

  seq_state_t state;
  logic       zero_q;
  logic       ovf_q;
  logic       in_byte_wait;
  logic       to_clr;
  logic       to_expire;

  function automatic logic [NB_DATA-1:0] flag_byte(input logic zero, input logic ovf);
    logic [NB_DATA-1:0] fb;
    fb               = '0;
    fb[FLG_ZERO_BIT] = zero;
    fb[FLG_OVF_BIT]  = ovf;
    return fb;
  endfunction

  // Timeout only guards the gaps after A and after B; an accepted byte restarts it.
  assign in_byte_wait = (state == ST_WAIT_B) || (state == ST_WAIT_OP);
  assign to_clr       = !in_byte_wait || i_rx_valid;

  alu_rx_sequencer_seq_timeout #(
    .NB_TIMEOUT  (NB_TIMEOUT),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (to_clr),
    .i_en     (in_byte_wait),
    .o_expire (to_expire)
  );

  // Outputs are registered for the state being entered, so each strobe
  // lines up with the cycle its state occupies.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state        <= ST_WAIT_A;
      o_data       <= '0;
      o_en_A       <= 1'b0;
      o_en_B       <= 1'b0;
      o_en_OP      <= 1'b0;
      o_tx_data    <= '0;
      o_tx_start   <= 1'b0;
      o_rx_overrun <= 1'b0;
      zero_q       <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      o_en_A       <= 1'b0;
      o_en_B       <= 1'b0;
      o_en_OP      <= 1'b0;
      o_tx_start   <= 1'b0;
      o_rx_overrun <= is_busy_state(state) && i_rx_valid;

      case (state)
        ST_WAIT_A: begin
          if (i_rx_valid) begin
            o_data <= i_rx_data;
            o_en_A <= 1'b1;
            state  <= ST_WAIT_B;
          end
        end
        ST_WAIT_B: begin
          if (i_rx_valid) begin
            o_data <= i_rx_data;
            o_en_B <= 1'b1;
            state  <= ST_WAIT_OP;
          end else if (to_expire) begin
            state <= ST_WAIT_A;
          end
        end
        ST_WAIT_OP: begin
          // The opcode strobe is the one that is high throughout EXEC.
          if (i_rx_valid) begin
            o_data  <= i_rx_data;
            o_en_OP <= 1'b1;
            state   <= ST_EXEC;
          end else if (to_expire) begin
            state <= ST_WAIT_A;
          end
        end
        ST_EXEC: begin
          state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          // All three ALU registers were loaded at the edge closing EXEC.
          zero_q     <= i_zero;
          ovf_q      <= i_overflow;
          o_tx_data  <= i_result;
          o_tx_start <= 1'b1;
          state      <= ST_TX_RES;
        end
        ST_TX_RES: begin
          state <= ST_WAIT_RES;
        end
        ST_WAIT_RES: begin
          if (i_tx_done) begin
            o_tx_data  <= flag_byte(zero_q, ovf_q);
            o_tx_start <= 1'b1;
            state      <= ST_TX_FLG;
          end
        end
        ST_TX_FLG: begin
          state <= ST_WAIT_FLG;
        end
        ST_WAIT_FLG: begin
          if (i_tx_done) begin
            state <= ST_WAIT_A;
          end
        end
        default: begin
          state <= ST_WAIT_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rx_sequencer.sv
// Directed and randomized bench for alu_rx_sequencer with a small ALU and
// transmitter environment and a behavioural reference for the returned bytes.
`define CHK(T, O, E) begin total++; assert ((O) === (E)) else begin bad++; $error("FAIL %s: observed=%0h expected=%0h", T, O, E); end end

module tb_alu_rx_sequencer;
  import alu_rx_sequencer_pkg::*;

  localparam int NB_DATA     = 8;
  localparam int NB_OP       = 6;
  localparam int NB_TIMEOUT  = 24;
  localparam int TIMEOUT_CYC = 16;

  logic         clk;
  logic         i_rst;
  logic [7:0]   i_rx_data;
  logic         i_rx_valid;
  logic [7:0]   o_data;
  logic         o_en_A, o_en_B, o_en_OP;
  logic [7:0]   i_result;
  logic         i_zero, i_overflow;
  logic [7:0]   o_tx_data;
  logic         o_tx_start;
  logic         i_tx_done;
  logic         o_rx_overrun;

  int total = 0;
  int bad   = 0;

  int         en_kind[$];
  logic [7:0] en_data[$];
  logic [7:0] tx_log[$];
  int         ovr_cnt   = 0;
  int         done_cnt  = 0;
  int         tx_delay  = 0;
  bit         spur_req  = 1'b0;

  alu_rx_sequencer #(
    .NB_DATA     (NB_DATA),
    .NB_OP       (NB_OP),
    .NB_TIMEOUT  (NB_TIMEOUT),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_rx_data    (i_rx_data),
    .i_rx_valid   (i_rx_valid),
    .o_data       (o_data),
    .o_en_A       (o_en_A),
    .o_en_B       (o_en_B),
    .o_en_OP      (o_en_OP),
    .i_result     (i_result),
    .i_zero       (i_zero),
    .i_overflow   (i_overflow),
    .o_tx_data    (o_tx_data),
    .o_tx_start   (o_tx_start),
    .i_tx_done    (i_tx_done),
    .o_rx_overrun (o_rx_overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ALU top stand-in: operand registers loaded by the strobes, combinational result.
  logic [7:0] alu_a, alu_b;
  logic [5:0] alu_op;

  always_ff @(posedge clk) begin
    if (o_en_A)  alu_a  <= o_data;
    if (o_en_B)  alu_b  <= o_data;
    if (o_en_OP) alu_op <= o_data[NB_OP-1:0];
  end

  always_comb begin
    i_result   = '0;
    i_overflow = 1'b0;
    case (alu_op)
      OP_ADD: begin
        i_result   = alu_a + alu_b;
        i_overflow = (alu_a[7] == alu_b[7]) && (i_result[7] != alu_a[7]);
      end
      OP_SUB: begin
        i_result   = alu_a - alu_b;
        i_overflow = (alu_a[7] != alu_b[7]) && (i_result[7] != alu_a[7]);
      end
      OP_AND:  i_result = alu_a & alu_b;
      OP_OR:   i_result = alu_a | alu_b;
      OP_XOR:  i_result = alu_a ^ alu_b;
      OP_NOR:  i_result = ~(alu_a | alu_b);
      OP_SRA:  i_result = $signed(alu_a) >>> alu_b;
      OP_SRL:  i_result = alu_a >> alu_b;
      default: i_result = '0;
    endcase
    i_zero = (i_result == 8'h00);
  end

  // Reference: result and flag byte from the operand values as integers.
  function automatic void ref_txn(input logic [7:0] a, input logic [7:0] b,
                                  input logic [7:0] op,
                                  output logic [7:0] res, output logic [7:0] flg);
    int sa, sb, v;
    bit ovf;
    sa  = $signed(a);
    sb  = $signed(b);
    ovf = 1'b0;
    case (op[5:0])
      OP_ADD:  begin v = sa + sb; ovf = (v > 127) || (v < -128); end
      OP_SUB:  begin v = sa - sb; ovf = (v > 127) || (v < -128); end
      OP_AND:  v = int'(a & b);
      OP_OR:   v = int'(a | b);
      OP_XOR:  v = int'(a ^ b);
      OP_NOR:  v = 255 - int'(a | b);
      OP_SRA:  v = (b > 7) ? ((sa < 0) ? -1 : 0) : (sa >>> b);
      OP_SRL:  v = (b > 7) ? 0 : (int'(a) >> b);
      default: v = 0;
    endcase
    res = v[7:0];
    flg = {6'b0, ovf, (res == 8'h00)};
  endfunction

  // Monitor: log strobes, count overrun cycles, check output exclusivity.
  initial begin
    forever begin
      @(negedge clk);
      if (o_en_A)  begin en_kind.push_back(0); en_data.push_back(o_data); end
      if (o_en_B)  begin en_kind.push_back(1); en_data.push_back(o_data); end
      if (o_en_OP) begin en_kind.push_back(2); en_data.push_back(o_data); end
      if (o_rx_overrun) ovr_cnt++;
      total++;
      if ((int'(o_en_A) + int'(o_en_B) + int'(o_en_OP) + int'(o_tx_start)) > 1) begin
        bad++;
        $error("FAIL strobe_excl: A=%0b B=%0b OP=%0b start=%0b", o_en_A, o_en_B, o_en_OP, o_tx_start);
      end
    end
  end

  // Transmitter stand-in: answers each start with done after tx_delay cycles.
  initial begin
    bit         busy;
    int         wait_left;
    logic [7:0] held;
    busy      = 1'b0;
    wait_left = 0;
    held      = '0;
    i_tx_done = 1'b0;
    forever begin
      @(negedge clk);
      i_tx_done = spur_req;
      spur_req  = 1'b0;
      if (!i_rst) begin
        busy = 1'b0;
      end else if (o_tx_start) begin
        total++;
        if (busy !== 1'b0) begin
          bad++;
          $error("FAIL tx_start_while_busy");
        end
        busy      = 1'b1;
        held      = o_tx_data;
        wait_left = tx_delay;
        tx_log.push_back(o_tx_data);
      end else if (busy) begin
        total++;
        if (o_tx_data !== held) begin
          bad++;
          $error("FAIL tx_data_stable: observed=%0h expected=%0h", o_tx_data, held);
        end
        if (wait_left == 0) begin
          i_tx_done = 1'b1;
          busy      = 1'b0;
          done_cnt++;
        end else begin
          wait_left--;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(negedge clk);
    i_rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic clear_logs();
    en_kind.delete();
    en_data.delete();
    tx_log.delete();
    ovr_cnt  = 0;
    done_cnt = 0;
  endtask

  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                         input int delay, input int gap_a, input bit inject,
                         input logic [7:0] exp_r, input logic [7:0] exp_f, input string tag);
    int cyc;
    clear_logs();
    tx_delay = delay;
    send_byte(a, gap_a);
    send_byte(b, 3);
    send_byte(op, 0);
    if (inject) begin
      cyc = 0;
      while (tx_log.size() < 1 && cyc < 200) begin @(negedge clk); cyc++; end
      tick(2);
      send_byte(8'hAA, 0);
    end
    cyc = 0;
    while (done_cnt < 2 && cyc < 3000) begin @(negedge clk); cyc++; end
    tick(3);
    `CHK($sformatf("%s_done", tag), done_cnt, 2)
    `CHK($sformatf("%s_nstrobe", tag), en_kind.size(), 3)
    if (en_kind.size() == 3) begin
      `CHK($sformatf("%s_kindA", tag), en_kind[0], 0)
      `CHK($sformatf("%s_busA", tag), en_data[0], a)
      `CHK($sformatf("%s_kindB", tag), en_kind[1], 1)
      `CHK($sformatf("%s_busB", tag), en_data[1], b)
      `CHK($sformatf("%s_kindOP", tag), en_kind[2], 2)
      `CHK($sformatf("%s_busOP", tag), en_data[2], op)
    end
    `CHK($sformatf("%s_ntx", tag), tx_log.size(), 2)
    if (tx_log.size() == 2) begin
      `CHK($sformatf("%s_res", tag), tx_log[0], exp_r)
      `CHK($sformatf("%s_flg", tag), tx_log[1], exp_f)
    end
    `CHK($sformatf("%s_overrun", tag), ovr_cnt, (inject ? 1 : 0))
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [20:0] outs;
    logic [7:0]  ops [8];
    logic [7:0]  ra, rb, rop, er, ef;
    int          cyc;
    ops = '{{2'b00, OP_ADD}, {2'b00, OP_SUB}, {2'b00, OP_AND}, {2'b00, OP_OR},
            {2'b00, OP_XOR}, {2'b00, OP_NOR}, {2'b00, OP_SRA}, {2'b00, OP_SRL}};

    i_rst      = 1'b1;
    i_rx_data  = '0;
    i_rx_valid = 1'b0;
    #1 i_rst = 1'b0;
    tick(3);
    outs = {o_data, o_en_A, o_en_B, o_en_OP, o_tx_data, o_tx_start, o_rx_overrun};
    total++;
    if (outs !== 21'h0) begin
      bad++;
      $error("FAIL reset_outputs: observed=%0h", outs);
    end
    i_rst = 1'b1;
    tick(2);

    // Directed transactions.
    run_txn(8'h03, 8'h04, {2'b00, OP_ADD}, 2, 3, 1'b0, 8'h07, 8'h00, "add");
    run_txn(8'h7F, 8'h01, {2'b00, OP_ADD}, 1, 3, 1'b0, 8'h80, 8'h02, "add_ovf");
    run_txn(8'h05, 8'h05, {2'b00, OP_SUB}, 1000, 3, 1'b0, 8'h00, 8'h01, "sub_slow_tx");
    run_txn(8'h80, 8'h01, {2'b00, OP_SUB}, 0, 3, 1'b0, 8'h7F, 8'h02, "sub_ovf");
    run_txn(8'h80, 8'h02, {2'b00, OP_SRA}, 0, 3, 1'b0, 8'hE0, 8'h00, "sra");
    run_txn(8'h0F, 8'hF0, {2'b11, OP_OR}, 20, 3, 1'b1, 8'hFF, 8'h00, "or_overrun");
    run_txn(8'h0C, 8'h0A, {2'b00, OP_XOR}, 0, 3, 1'b0, 8'h06, 8'h00, "xor_after_ovr");

    // A stray done while idle must not start anything.
    clear_logs();
    spur_req = 1'b1;
    tick(5);
    `CHK("spurious_done_tx", tx_log.size(), 0)

    // Timeout: silence after A returns to WAIT_A; the following bytes are a fresh A/B/OP.
    clear_logs();
    send_byte(8'h10, TIMEOUT_CYC + 4);
    `CHK("timeout_only_A", en_kind.size(), 1)
    run_txn(8'h21, 8'h13, {2'b00, OP_SUB}, 0, 3, 1'b0, 8'h0E, 8'h00, "after_timeout");
    clear_logs();
    send_byte(8'h10, TIMEOUT_CYC - 1);
    run_txn(8'h21, 8'h13, {2'b00, OP_SUB}, 0, 3, 1'b0, 8'h0E, 8'h00, "timeout_edge");
    run_txn(8'h11, 8'h22, {2'b00, OP_ADD}, 0, TIMEOUT_CYC - 2, 1'b0, 8'h33, 8'h00, "byte_wins");

    // Reset while waiting for the flag byte to finish.
    clear_logs();
    tx_delay = 30;
    send_byte(8'h7F, 3);
    send_byte(8'h01, 3);
    send_byte({2'b00, OP_ADD}, 0);
    cyc = 0;
    while (tx_log.size() < 2 && cyc < 300) begin @(negedge clk); cyc++; end
    tick(3);
    #2 i_rst = 1'b0;
    #1;
    outs = {o_data, o_en_A, o_en_B, o_en_OP, o_tx_data, o_tx_start, o_rx_overrun};
    total++;
    if (outs !== 21'h0) begin
      bad++;
      $error("FAIL rst_wait_flg_outputs: observed=%0h", outs);
    end
    tick(2);
    i_rst = 1'b1;
    tick(40);
    `CHK("rst_no_more_done", done_cnt, 1)
    `CHK("rst_no_more_start", tx_log.size(), 2)

    // Reset between A and B.
    clear_logs();
    send_byte(8'h10, 3);
    #2 i_rst = 1'b0;
    #1;
    outs = {o_data, o_en_A, o_en_B, o_en_OP, o_tx_data, o_tx_start, o_rx_overrun};
    total++;
    if (outs !== 21'h0) begin
      bad++;
      $error("FAIL rst_between_AB_outputs: observed=%0h", outs);
    end
    tick(2);
    i_rst = 1'b1;
    tick(2);
    run_txn(8'h05, 8'h0A, {2'b00, OP_NOR}, 2, 3, 1'b0, 8'hF0, 8'h00, "after_reset");

    // Randomized transactions against the reference.
    for (int i = 0; i < 10; i++) begin
      rop = {2'($urandom), ops[$urandom_range(0, 7)][5:0]};
      ra  = 8'($urandom);
      rb  = (rop[5:0] == OP_SRA || rop[5:0] == OP_SRL) ? 8'($urandom_range(0, 9)) : 8'($urandom);
      ref_txn(ra, rb, rop, er, ef);
      run_txn(ra, rb, rop, $urandom_range(0, 4), 3, 1'b0, er, ef, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
